// File: rtl/result_packer.sv
// Packs K lanes of INT8/16/32/64 results (low P bits of each 64-bit lane) densely
// into K*DATA_WIDTH-bit output words, with valid/ready on both sides and tile-end flush.
module result_packer #(
  parameter int K                      = 4,
  parameter int DATA_WIDTH             = 64,
  parameter int LOG_ALLOWED_PRECISIONS = 3
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [LOG_ALLOWED_PRECISIONS-1:0] data_select,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [K*DATA_WIDTH-1:0]           in_data,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [K*DATA_WIDTH-1:0]           out_data,
  output logic                              out_last,
  output logic                              busy,
  output logic [1:0]                        dbg_state
);

  localparam logic [LOG_ALLOWED_PRECISIONS-1:0] INT8  = 0;
  localparam logic [LOG_ALLOWED_PRECISIONS-1:0] INT16 = 1;
  localparam logic [LOG_ALLOWED_PRECISIONS-1:0] INT32 = 2;
  localparam logic [LOG_ALLOWED_PRECISIONS-1:0] INT64 = 3;

  // Handshake: a beat moves on either side only in a cycle where valid && ready
  // are both high at the rising edge; valid never depends on ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1
  } state_t;

  state_t                              r_state;
  state_t                              w_state_nxt;
  logic [2:0]                          r_cnt;
  logic [LOG_ALLOWED_PRECISIONS-1:0]   r_prec;
  logic [K*DATA_WIDTH-1:0]             r_acc;
  logic [K*DATA_WIDTH-1:0]             r_out_data;
  logic                                r_out_valid;
  logic                                r_out_last;

  logic [LOG_ALLOWED_PRECISIONS-1:0]   w_prec;
  logic [K*DATA_WIDTH-1:0]             w_placed;
  logic [2:0]                          w_last_idx;
  logic                                w_accept;
  logic                                w_close;

  // The first beat of a group uses the live select; later beats use the latched one.
  assign w_prec   = (r_state == S_IDLE) ? data_select : r_prec;
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_close  = w_accept && ((r_cnt == w_last_idx) || in_last);

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_cnt != 3'd0);
  assign dbg_state = r_state;

  always_comb begin
    w_placed   = '0;
    w_last_idx = 3'd0;
    case (w_prec)
      INT8: begin
        w_last_idx = 3'd7;
        for (int j = 0; j < K; j++)
          w_placed[(int'(r_cnt) * K + j) * 8 +: 8] = in_data[j*DATA_WIDTH +: 8];
      end
      INT16: begin
        w_last_idx = 3'd3;
        for (int j = 0; j < K; j++)
          w_placed[(int'(r_cnt[1:0]) * K + j) * 16 +: 16] = in_data[j*DATA_WIDTH +: 16];
      end
      INT32: begin
        w_last_idx = 3'd1;
        for (int j = 0; j < K; j++)
          w_placed[(int'(r_cnt[0]) * K + j) * 32 +: 32] = in_data[j*DATA_WIDTH +: 32];
      end
      INT64: begin
        for (int j = 0; j < K; j++)
          w_placed[j*64 +: 64] = in_data[j*DATA_WIDTH +: 64];
      end
      default: begin
        // Unknown precision behaves as a one-beat group that packs to zero.
        w_last_idx = 3'd0;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && !w_close) w_state_nxt = S_FILL;
      S_FILL: if (w_close) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt       <= 3'd0;
      r_prec      <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_accept && (r_state == S_IDLE))
        r_prec <= data_select;
      if (w_close) begin
        // Overwrites the output register; in_ready guarantees the old word has left.
        r_out_data  <= r_acc | w_placed;
        r_out_last  <= in_last;
        r_out_valid <= 1'b1;
        r_acc       <= '0;
        r_cnt       <= 3'd0;
      end else begin
        if (w_accept) begin
          r_acc <= r_acc | w_placed;
          r_cnt <= r_cnt + 3'd1;
        end
        if (r_out_valid && out_ready)
          r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_result_packer.sv
// Directed bench for result_packer: a group-level model builds expected words
// from accepted beats; a per-cycle compare checks handshake, data and busy.
module tb_result_packer;

  localparam logic [2:0] C_INT8  = 3'd0;
  localparam logic [2:0] C_INT16 = 3'd1;
  localparam logic [2:0] C_INT32 = 3'd2;
  localparam logic [2:0] C_INT64 = 3'd3;

  logic         clk = 1'b0;
  logic         aresetn = 1'b0;
  logic [2:0]   data_select = C_INT8;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [255:0] out_data;
  logic         out_last;
  logic         busy;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;

  result_packer #(.K(4), .DATA_WIDTH(64), .LOG_ALLOWED_PRECISIONS(3)) dut (
    .clk(clk), .aresetn(aresetn), .data_select(data_select),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- model / scoreboard ----------------
  logic [255:0] exp_q[$];
  logic         exp_last_q[$];
  logic [63:0]  m_elem[32];
  int           m_n;
  logic [2:0]   m_prec;

  task automatic model_accept(input logic [2:0] sel, input logic [255:0] d, input logic last);
    int p;
    bit ok;
    logic [255:0] word;
    logic [255:0] mask;
    if (m_n == 0) m_prec = sel;
    ok = 1;
    case (m_prec)
      C_INT8:  p = 8;
      C_INT16: p = 16;
      C_INT32: p = 32;
      C_INT64: p = 64;
      default: begin p = 64; ok = 0; end
    endcase
    for (int j = 0; j < 4; j++) m_elem[m_n*4 + j] = d[j*64 +: 64];
    m_n++;
    if (m_n == 64 / p || last) begin
      word = '0;
      mask = (256'd1 << p) - 256'd1;
      if (ok)
        for (int e = 0; e < m_n * 4; e++)
          word = word | ((256'(m_elem[e]) & mask) << (e * p));
      exp_q.push_back(word);
      exp_last_q.push_back(last);
      m_n = 0;
    end
  endtask

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      exp_q.delete();
      exp_last_q.delete();
      m_n = 0;
    end else begin
      if (out_valid && out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        void'(exp_last_q.pop_front());
      end
      if (in_valid && in_ready) model_accept(data_select, in_data, in_last);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] lanes4(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c, input logic [63:0] d);
    return {d, c, b, a};
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send_beat(input logic [2:0] sel, input logic [255:0] d, input logic last);
    int w;
    w = 0;
    data_select = sel;
    in_data     = d;
    in_last     = last;
    in_valid    = 1'b1;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_timeout", {255'd0, in_ready}, 256'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // ---------------- stimulus + compare ----------------
  initial begin
    logic [255:0] d;
    logic [255:0] held;
    fork
      begin : compare
        forever begin
          @(negedge clk);
          #1;
          if (aresetn) begin
            chk("cmp_out_valid", {255'd0, out_valid}, {255'd0, exp_q.size() != 0});
            if (out_valid && exp_q.size() != 0) begin
              chk("cmp_out_data", out_data, exp_q[0]);
              chk("cmp_out_last", {255'd0, out_last}, {255'd0, exp_last_q[0]});
            end
            chk("cmp_in_ready", {255'd0, in_ready}, {255'd0, (!out_valid || out_ready)});
            chk("cmp_busy", {255'd0, busy}, {255'd0, m_n != 0});
          end
        end
      end
      begin : stim
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {255'd0, in_ready}, 256'd1);
        chk("rst_out_valid", {255'd0, out_valid}, 256'd0);
        chk("rst_out_data", out_data, 256'd0);
        chk("rst_out_last", {255'd0, out_last}, 256'd0);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        aresetn = 1'b1;
        @(negedge clk);

        // INT64 single beat
        send_beat(C_INT64, lanes4(64'h1, 64'h2, 64'h3, 64'h4), 1'b0);
        chk("t1_valid", {255'd0, out_valid}, 256'd1);
        chk("t1_data", out_data, {64'h4, 64'h3, 64'h2, 64'h1});
        chk("t1_last", {255'd0, out_last}, 256'd0);
        @(negedge clk);

        // INT8 eight beats, upper lane bits truncated
        for (int n = 0; n < 8; n++) begin
          d = lanes4(64'hFFFF_FF00 | 64'(4*n+1), 64'hFFFF_FF00 | 64'(4*n+2),
                     64'hFFFF_FF00 | 64'(4*n+3), 64'hFFFF_FF00 | 64'(4*n+4));
          send_beat(C_INT8, d, 1'b0);
          if (n < 7) chk("t2_busy", {255'd0, busy}, 256'd1);
        end
        chk("t2_valid", {255'd0, out_valid}, 256'd1);
        chk("t2_lo", {192'd0, out_data[63:0]}, {192'd0, 64'h0807060504030201});
        chk("t2_hi", {192'd0, out_data[255:192]}, {192'd0, 64'h201F1E1D1C1B1A19});
        @(negedge clk);

        // INT16 flush after two beats
        send_beat(C_INT16, lanes4(64'd1, 64'd2, 64'd3, 64'd4), 1'b0);
        send_beat(C_INT16, lanes4(64'd5, 64'd6, 64'd7, 64'd8), 1'b1);
        chk("t3_last", {255'd0, out_last}, 256'd1);
        chk("t3_lo", {128'd0, out_data[127:0]}, {128'd0, 128'h0008_0007_0006_0005_0004_0003_0002_0001});
        chk("t3_hi", {128'd0, out_data[255:128]}, 256'd0);
        @(negedge clk);

        // Backpressure, then simultaneous out handshake and closing beat
        out_ready = 1'b0;
        send_beat(C_INT32, lanes4(64'd1, 64'd2, 64'd3, 64'd4), 1'b0);
        send_beat(C_INT32, lanes4(64'd5, 64'd6, 64'd7, 64'd8), 1'b0);
        held = out_data;
        repeat (3) @(negedge clk);
        chk("t4_in_ready", {255'd0, in_ready}, 256'd0);
        chk("t4_valid", {255'd0, out_valid}, 256'd1);
        chk("t4_stable", out_data, held);
        chk("t4_data", out_data, 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
        out_ready = 1'b1;
        send_beat(C_INT32, lanes4(64'd9, 64'd10, 64'd11, 64'd12), 1'b1);
        out_ready = 1'b0;
        chk("t4_reload_valid", {255'd0, out_valid}, 256'd1);
        chk("t4_reload_data", out_data, {128'd0, 128'h0000000C_0000000B_0000000A_00000009});
        chk("t4_reload_last", {255'd0, out_last}, 256'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_drained", {255'd0, out_valid}, 256'd0);

        // Async reset mid-group
        send_beat(C_INT32, lanes4(64'd1, 64'd2, 64'd3, 64'd4), 1'b0);
        chk("t5_busy_pre", {255'd0, busy}, 256'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("t5_busy_rst", {255'd0, busy}, 256'd0);
        chk("t5_valid_rst", {255'd0, out_valid}, 256'd0);
        chk("t5_data_rst", out_data, 256'd0);
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        send_beat(C_INT32, lanes4(64'd21, 64'd22, 64'd23, 64'd24), 1'b0);
        send_beat(C_INT32, lanes4(64'd25, 64'd26, 64'd27, 64'd28), 1'b0);
        chk("t5_data", out_data, 256'h0000001C_0000001B_0000001A_00000019_00000018_00000017_00000016_00000015);
        @(negedge clk);

        // Select change mid-group is ignored until the group closes
        for (int n = 0; n < 8; n++) begin
          d = lanes4(64'(4*n+1), 64'(4*n+2), 64'(4*n+3), 64'(4*n+4));
          send_beat((n == 0) ? C_INT8 : C_INT16, d, 1'b0);
        end
        chk("t6_int8_lo", {192'd0, out_data[63:0]}, {192'd0, 64'h0807060504030201});
        chk("t6_int8_hi", {192'd0, out_data[255:192]}, {192'd0, 64'h201F1E1D1C1B1A19});
        @(negedge clk);
        for (int n = 0; n < 4; n++) begin
          d = lanes4(64'hABCD_0000 | 64'(4*n+1), 64'hABCD_0000 | 64'(4*n+2),
                     64'hABCD_0000 | 64'(4*n+3), 64'hABCD_0000 | 64'(4*n+4));
          send_beat(C_INT16, d, 1'b0);
        end
        chk("t6_int16_lo", {192'd0, out_data[63:0]}, {192'd0, 64'h0004_0003_0002_0001});
        chk("t6_int16_hi", {192'd0, out_data[255:192]}, {192'd0, 64'h0010_000F_000E_000D});
        @(negedge clk);

        // Unsupported code packs to zero in one beat
        send_beat(3'd5, lanes4(64'd1, 64'd2, 64'd3, 64'd4), 1'b0);
        chk("t7_valid", {255'd0, out_valid}, 256'd1);
        chk("t7_data", out_data, 256'd0);
        chk("t7_busy", {255'd0, busy}, 256'd0);
        @(negedge clk);

        // INT8 partial flush after three beats
        for (int n = 0; n < 3; n++) begin
          d = lanes4(64'(4*n+1), 64'(4*n+2), 64'(4*n+3), 64'(4*n+4));
          send_beat(C_INT8, d, n == 2);
        end
        chk("t8_data", out_data, {160'd0, 96'h0C0B0A09_0807060504030201});
        chk("t8_last", {255'd0, out_last}, 256'd1);
        repeat (3) @(negedge clk);
      end
      begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
